// File: rtl/fwd_pkg.sv
// Shared encodings for the forwarding/hazard unit: selector codes and hazard FSM states.
package fwd_pkg;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_WB    = 2'b11;

  typedef enum logic {
    HZ_RUN   = 1'b0,
    HZ_STALL = 1'b1
  } hz_state_e;
endpackage

// File: rtl/fwd_src_cmp.sv
// Per-operand destination comparator and newest-producer-first priority encoder.
// Purely combinational; never stalls.
module fwd_src_cmp
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W  = 3,
  parameter int ZERO_REG_EN = 0
) (
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic                  src_valid,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  ex_wb_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic                  wb_wb_en,
  output logic [1:0]            sel_next,
  output logic                  match_ex
);
  logic src_live;
  logic match_mem;
  logic match_wb;

  always_comb begin
    // The hardwired-zero register can never be a forwarding target.
    src_live  = src_valid & ~((ZERO_REG_EN != 0) && (src_addr == '0));
    match_ex  = src_live & ex_wb_en  & (src_addr == ex_dest);
    match_mem = src_live & mem_wb_en & (src_addr == mem_dest);
    match_wb  = src_live & wb_wb_en  & (src_addr == wb_dest);

    sel_next = FWD_RF;
    if (match_ex)       sel_next = FWD_EXMEM;
    else if (match_mem) sel_next = FWD_MEMWB;
    else if (match_wb)  sel_next = FWD_WB;
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding selector register plus load-use stall FSM and saturating stall counter.
// Selectors appear 1 cycle after ID; stall/bubble are combinational (0 cycles) and flush overrides them.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W        = 3,
  parameter int NUM_SRC           = 2,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int ZERO_REG_EN       = 0,
  parameter int PERF_W            = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]   id_src_addr,
  input  logic [NUM_SRC-1:0]              id_src_valid,
  input  logic [REG_ADDR_W-1:0]           ex_dest,
  input  logic                            ex_wb_en,
  input  logic                            ex_is_load,
  input  logic [REG_ADDR_W-1:0]           mem_dest,
  input  logic                            mem_wb_en,
  input  logic [REG_ADDR_W-1:0]           wb_dest,
  input  logic                            wb_wb_en,
  input  logic                            flush,
  input  logic                            perf_clr,
  output logic [NUM_SRC*2-1:0]            fwd_sel_q,
  output logic                            stall,
  output logic                            bubble,
  output logic [PERF_W-1:0]               stall_cycles
);
  localparam logic [3:0] CNT_INIT =
    (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  logic [NUM_SRC*2-1:0] sel_next;
  logic [NUM_SRC-1:0]   match_ex;
  logic                 hazard;

  hz_state_e            state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [NUM_SRC*2-1:0] fwd_sel_d;
  logic [PERF_W-1:0]    stall_cycles_q, stall_cycles_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_cmp
    fwd_src_cmp #(
      .REG_ADDR_W  (REG_ADDR_W),
      .ZERO_REG_EN (ZERO_REG_EN)
    ) u_cmp (
      .src_addr  (id_src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
      .src_valid (id_src_valid[i]),
      .ex_dest   (ex_dest),
      .ex_wb_en  (ex_wb_en),
      .mem_dest  (mem_dest),
      .mem_wb_en (mem_wb_en),
      .wb_dest   (wb_dest),
      .wb_wb_en  (wb_wb_en),
      .sel_next  (sel_next[2*i +: 2]),
      .match_ex  (match_ex[i])
    );
  end

  always_comb begin
    hazard  = ex_is_load & (|match_ex);
    stall   = ~flush & ((state_q == HZ_STALL) | hazard);
    bubble  = stall;

    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = HZ_RUN;
      cnt_d   = 4'd0;
    end else if (state_q == HZ_RUN) begin
      if (hazard && (LOAD_STALL_CYCLES > 1)) begin
        state_d = HZ_STALL;
        cnt_d   = CNT_INIT;
      end
    end else if (cnt_q == 4'd0) begin
      state_d = HZ_RUN;
    end else begin
      cnt_d = cnt_q - 4'd1;
    end

    // A bubbled EX slot must read the register file, not a stale bypass.
    fwd_sel_d = (flush | stall) ? '0 : sel_next;

    stall_cycles_d = stall_cycles_q;
    if (perf_clr)                                 stall_cycles_d = '0;
    else if (stall && stall_cycles_q != PERF_MAX) stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= HZ_RUN;
      cnt_q          <= 4'd0;
      fwd_sel_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      fwd_sel_q      <= fwd_sel_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed and random checks of fwd_hazard_unit against a cycle-level reference model.
module tb_fwd_hazard_unit;
  localparam int W    = 3;
  localparam int NS   = 2;
  localparam int LSC  = 3;
  localparam int ZR   = 1;
  localparam int PW   = 4;
  localparam int PMAX = (1 << PW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS*W-1:0]   id_src_addr;
  logic [NS-1:0]     id_src_valid;
  logic [W-1:0]      ex_dest, mem_dest, wb_dest;
  logic              ex_wb_en, ex_is_load, mem_wb_en, wb_wb_en;
  logic              flush, perf_clr;
  logic [NS*2-1:0]   fwd_sel_q;
  logic              stall, bubble;
  logic [PW-1:0]     stall_cycles;

  fwd_hazard_unit #(
    .REG_ADDR_W        (W),
    .NUM_SRC           (NS),
    .LOAD_STALL_CYCLES (LSC),
    .ZERO_REG_EN       (ZR),
    .PERF_W            (PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_src_addr  (id_src_addr),
    .id_src_valid (id_src_valid),
    .ex_dest      (ex_dest),
    .ex_wb_en     (ex_wb_en),
    .ex_is_load   (ex_is_load),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .wb_dest      (wb_dest),
    .wb_wb_en     (wb_wb_en),
    .flush        (flush),
    .perf_clr     (perf_clr),
    .fwd_sel_q    (fwd_sel_q),
    .stall        (stall),
    .bubble       (bubble),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: remaining stall cycles after the current one, registered selectors, perf count.
  int         m_left, m_perf, n_left, n_perf;
  logic [3:0] m_sel, n_sel;
  logic       m_stall;

  function automatic int src_of(int i);
    return int'((id_src_addr >> (i * W)) & ((1 << W) - 1));
  endfunction

  function automatic int ref_code(int i);
    int s;
    s = src_of(i);
    if (!id_src_valid[i] || (ZR != 0 && s == 0)) return 0;
    if (ex_wb_en  && s == int'(ex_dest))  return 1;
    if (mem_wb_en && s == int'(mem_dest)) return 2;
    if (wb_wb_en  && s == int'(wb_dest))  return 3;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_src_addr = '0; id_src_valid = '0;
    ex_dest = '0; mem_dest = '0; wb_dest = '0;
    ex_wb_en = 0; ex_is_load = 0; mem_wb_en = 0; wb_wb_en = 0;
    flush = 0; perf_clr = 0; rst = 0;
  endtask

  // Check outputs mid-cycle against the model and work out the model's next state.
  task automatic eval();
    bit hz;
    @(negedge clk);
    hz = ex_is_load && (ref_code(0) == 1 || ref_code(1) == 1);
    m_stall = !flush && (m_left > 0 || hz);
    chk("m_stall",  32'(stall),        32'(m_stall));
    chk("m_bubble", 32'(bubble),       32'(m_stall));
    chk("m_sel",    32'(fwd_sel_q),    32'(m_sel));
    chk("m_perf",   32'(stall_cycles), 32'(m_perf));
    if (rst) begin
      n_sel = 0; n_left = 0; n_perf = 0;
    end else begin
      n_sel  = (flush || m_stall) ? 4'd0 : 4'((ref_code(1) << 2) | ref_code(0));
      n_left = flush ? 0 : (m_left > 0 ? m_left - 1 : (hz ? LSC - 1 : 0));
      n_perf = perf_clr ? 0 : (m_stall ? (m_perf < PMAX ? m_perf + 1 : PMAX) : m_perf);
    end
  endtask

  task automatic step_end();
    @(posedge clk);
    #1;
    m_sel = n_sel; m_left = n_left; m_perf = n_perf;
  endtask

  task automatic cyc();
    eval();
    step_end();
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    m_sel = 0; m_left = 0; m_perf = 0;
    rst = 0;

    // Reset state
    eval();
    chk("rst_sel", 32'(fwd_sel_q), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_perf", 32'(stall_cycles), 0);
    step_end();

    // EX forward on operand 0
    ex_dest = 3; ex_wb_en = 1; id_src_addr = 6'(3); id_src_valid = 2'b01;
    eval(); chk("ex_fwd_stall", 32'(stall), 0); step_end();
    eval(); chk("ex_fwd_sel0", 32'(fwd_sel_q[1:0]), 1); step_end();

    // Priority EX > MEM > WB on operand 1
    idle();
    ex_dest = 5; mem_dest = 5; wb_dest = 5;
    ex_wb_en = 1; mem_wb_en = 1; wb_wb_en = 1;
    id_src_addr = {3'd5, 3'd1}; id_src_valid = 2'b10;
    cyc();
    eval(); chk("prio_ex", 32'(fwd_sel_q[3:2]), 1); step_end();
    ex_wb_en = 0;
    cyc();
    eval(); chk("prio_mem", 32'(fwd_sel_q[3:2]), 2); step_end();
    mem_wb_en = 0;
    cyc();
    eval(); chk("prio_wb", 32'(fwd_sel_q[3:2]), 3); step_end();

    // Both operands on the same producer
    idle();
    mem_dest = 4; mem_wb_en = 1; id_src_addr = {3'd4, 3'd4}; id_src_valid = 2'b11;
    cyc();
    eval(); chk("dual_sel", 32'(fwd_sel_q), 4'b1010); step_end();

    // Load-use: three stall cycles, then the load sits in MEM
    idle(); perf_clr = 1; cyc(); perf_clr = 0;
    ex_is_load = 1; ex_wb_en = 1; ex_dest = 2; id_src_addr = 6'(2); id_src_valid = 2'b01;
    eval(); chk("lu_stall0", 32'(stall), 1); step_end();
    ex_is_load = 0; ex_wb_en = 0; mem_dest = 2; mem_wb_en = 1;
    for (int k = 1; k < 3; k++) begin
      eval(); chk("lu_stall_n", 32'(stall), 1); chk("lu_sel0", 32'(fwd_sel_q), 0); step_end();
    end
    eval();
    chk("lu_release", 32'(stall), 0);
    chk("lu_perf", 32'(stall_cycles), 3);
    chk("lu_sel_bubble", 32'(fwd_sel_q), 0);
    step_end();
    eval(); chk("lu_sel_mem", 32'(fwd_sel_q[1:0]), 2); step_end();

    // Flush in the second stall cycle
    idle();
    ex_is_load = 1; ex_wb_en = 1; ex_dest = 2; id_src_addr = 6'(2); id_src_valid = 2'b01;
    eval(); chk("fl_stall", 32'(stall), 1); step_end();
    ex_is_load = 0; ex_wb_en = 0; mem_dest = 2; mem_wb_en = 1; flush = 1;
    eval(); chk("fl_block", 32'(stall), 0); step_end();
    flush = 0;
    eval(); chk("fl_run", 32'(stall), 0); chk("fl_sel", 32'(fwd_sel_q), 0); step_end();

    // Hardwired zero register and invalid operand
    idle();
    ex_is_load = 1; ex_wb_en = 1; ex_dest = 0; id_src_addr = 6'(0); id_src_valid = 2'b01;
    eval(); chk("zr_stall", 32'(stall), 0); step_end();
    eval(); chk("zr_sel", 32'(fwd_sel_q[1:0]), 0); step_end();
    ex_is_load = 0; ex_dest = 3; id_src_addr = 6'(3); id_src_valid = 2'b00;
    cyc();
    eval(); chk("inv_sel", 32'(fwd_sel_q[1:0]), 0); step_end();

    // Saturation, clear during stall, reset mid-stall
    idle();
    ex_is_load = 1; ex_wb_en = 1; ex_dest = 6; id_src_addr = 6'(6); id_src_valid = 2'b01;
    repeat (20) cyc();
    eval(); chk("sat_perf", 32'(stall_cycles), PMAX); chk("sat_stall", 32'(stall), 1); step_end();
    perf_clr = 1;
    eval(); chk("clr_stall", 32'(stall), 1); step_end();
    perf_clr = 0;
    eval(); chk("clr_perf", 32'(stall_cycles), 0); step_end();
    ex_is_load = 0;
    repeat (3) cyc();
    ex_is_load = 1;
    cyc();
    ex_is_load = 0; rst = 1;
    eval(); chk("rst_mid_stall", 32'(stall), 1); step_end();
    idle();
    eval();
    chk("rst2_sel", 32'(fwd_sel_q), 0);
    chk("rst2_stall", 32'(stall), 0);
    chk("rst2_perf", 32'(stall_cycles), 0);
    step_end();

    // Random traffic over a small address range to provoke matches
    for (int n = 0; n < 400; n++) begin
      id_src_addr  = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
      id_src_valid = 2'($urandom);
      ex_dest      = 3'($urandom_range(0, 3));
      mem_dest     = 3'($urandom_range(0, 3));
      wb_dest      = 3'($urandom_range(0, 3));
      ex_wb_en     = 1'($urandom);
      mem_wb_en    = 1'($urandom);
      wb_wb_en     = 1'($urandom);
      ex_is_load   = 1'($urandom);
      flush        = ($urandom_range(0, 9) == 0);
      perf_clr     = ($urandom_range(0, 19) == 0);
      rst          = ($urandom_range(0, 49) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
